// File: rtl/renkon_accum_pkg.sv
// renkon_accum_pkg: data width, accumulator state encoding and the saturating add
// shared by the renkon_accum channel accumulator.
package renkon_accum_pkg;

    localparam int DWIDTH = 16;
    localparam logic signed [DWIDTH-1:0] SMAX = {1'b0, {(DWIDTH-1){1'b1}}};
    localparam logic signed [DWIDTH-1:0] SMIN = {1'b1, {(DWIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACC, FLUSH} accum_state_e;

    // One guard bit detects overflow; clamp to the signed DWIDTH range.
    function automatic logic signed [DWIDTH-1:0] sat_add(
        input logic signed [DWIDTH-1:0] a,
        input logic signed [DWIDTH-1:0] b
    );
        logic signed [DWIDTH:0] s;
        s = {a[DWIDTH-1], a} + {b[DWIDTH-1], b};
        return (s[DWIDTH] == s[DWIDTH-1]) ? s[DWIDTH-1:0] : (s[DWIDTH] ? SMIN : SMAX);
    endfunction

endpackage

// File: rtl/renkon_accum_ram.sv
// renkon_accum_ram: simple dual-port partial-sum RAM, 1-cycle synchronous read,
// write-first bypass when read and write hit the same address.
module renkon_accum_ram #(
    parameter int AWIDTH = 10,
    parameter int DWIDTH = 16
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AWIDTH-1:0] waddr_i,
    input  logic [DWIDTH-1:0] wdata_i,
    input  logic [AWIDTH-1:0] raddr_i,
    output logic [DWIDTH-1:0] rdata_o
);

    logic [DWIDTH-1:0] mem [2**AWIDTH];

    always_ff @(posedge clk) begin
        if (we_i) mem[waddr_i] <= wdata_i;
        rdata_o <= (we_i && waddr_i == raddr_i) ? wdata_i : mem[raddr_i];
    end

endmodule

// File: rtl/renkon_accum.sv
// renkon_accum: sums per-input-channel partial maps into one output map with bias,
// saturation and optional ReLU (macro RENKON_ACCUM_RELU_EN).
module renkon_accum
    import renkon_accum_pkg::*;
#(
    parameter int AWIDTH  = 10,
    parameter int CHWIDTH = 10
) (
    input  logic                     clk,
    input  logic                     xrst,
    input  logic                     start,
    input  logic [CHWIDTH-1:0]       n_in,
    input  logic [AWIDTH:0]          img_size,
    input  logic signed [DWIDTH-1:0] bias,
    input  logic                     in_valid,
    input  logic signed [DWIDTH-1:0] fmap,
    output logic                     out_valid,
    output logic signed [DWIDTH-1:0] out_data,
    output logic                     busy,
    output logic                     done
);

    accum_state_e             state_q, state_d;
    logic [CHWIDTH-1:0]       n_in_q, ch_cnt_q, ch_cnt_d;
    logic [AWIDTH:0]          img_size_q;
    logic signed [DWIDTH-1:0] bias_q;
    logic [AWIDTH-1:0]        pix_cnt_q, pix_cnt_d;
    logic                     fcnt_q, fcnt_d, done_q, done_d;
    logic                     accept, pix_wrap, first_ch, last_ch;
    logic                     s1_valid_q, s1_first_q, s1_last_q;
    logic [AWIDTH-1:0]        s1_addr_q;
    logic signed [DWIDTH-1:0] s1_fmap_q;
    logic                     s2_valid_q, s2_last_q;
    logic [AWIDTH-1:0]        s2_addr_q;
    logic signed [DWIDTH-1:0] s2_sum_q;
    logic signed [DWIDTH-1:0] ram_rdata, sum_d, res_d;

    assign accept   = state_q == ACC && in_valid && !start;
    assign pix_wrap = {1'b0, pix_cnt_q} == img_size_q - 1'b1;
    assign first_ch = ch_cnt_q == '0;
    assign last_ch  = ch_cnt_q == n_in_q - 1'b1;

    always_comb begin
        state_d   = state_q;
        pix_cnt_d = pix_cnt_q;
        ch_cnt_d  = ch_cnt_q;
        fcnt_d    = 1'b0;
        if (start) begin
            state_d   = ACC;
            pix_cnt_d = '0;
            ch_cnt_d  = '0;
        end else if (state_q == ACC && accept) begin
            pix_cnt_d = pix_wrap ? '0 : pix_cnt_q + 1'b1;
            ch_cnt_d  = pix_wrap ? ch_cnt_q + 1'b1 : ch_cnt_q;
            state_d   = (pix_wrap && last_ch) ? FLUSH : ACC;
        end else if (state_q == FLUSH) begin
            fcnt_d  = 1'b1;
            state_d = fcnt_q ? IDLE : FLUSH;
        end
    end

    assign done_d = state_q == FLUSH && fcnt_q && !start;

    // The first channel seeds the sum with bias; the stale RAM word is ignored.
    assign sum_d = sat_add(s1_first_q ? bias_q : ram_rdata, s1_fmap_q);
`ifdef RENKON_ACCUM_RELU_EN
    assign res_d = (s1_last_q && sum_d[DWIDTH-1]) ? '0 : sum_d;
`else
    assign res_d = sum_d;
`endif

    renkon_accum_ram #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) u_ram (
        .clk     (clk),
        .we_i    (s2_valid_q && !s2_last_q),
        .waddr_i (s2_addr_q),
        .wdata_i (s2_sum_q),
        .raddr_i (pix_cnt_q),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state_q    <= IDLE;
            pix_cnt_q  <= '0;
            ch_cnt_q   <= '0;
            fcnt_q     <= 1'b0;
            done_q     <= 1'b0;
            n_in_q     <= '0;
            img_size_q <= '0;
            bias_q     <= '0;
            s1_valid_q <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_addr_q  <= '0;
            s1_fmap_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_addr_q  <= '0;
            s2_sum_q   <= '0;
        end else begin
            state_q    <= state_d;
            pix_cnt_q  <= pix_cnt_d;
            ch_cnt_q   <= ch_cnt_d;
            fcnt_q     <= fcnt_d;
            done_q     <= done_d;
            if (start) begin
                n_in_q     <= (n_in == '0) ? CHWIDTH'(1) : n_in;
                img_size_q <= img_size;
                bias_q     <= bias;
            end
            s1_valid_q <= accept;
            s1_first_q <= first_ch;
            s1_last_q  <= last_ch;
            s1_addr_q  <= pix_cnt_q;
            s1_fmap_q  <= fmap;
            // A restart drops whatever is still in flight.
            s2_valid_q <= s1_valid_q && !start;
            if (s1_valid_q) begin
                s2_last_q <= s1_last_q;
                s2_addr_q <= s1_addr_q;
                s2_sum_q  <= res_d;
            end
        end
    end

    assign out_valid = s2_valid_q && s2_last_q;
    assign out_data  = s2_sum_q;
    assign busy      = state_q != IDLE;
    assign done      = done_q;

endmodule
